// File: rtl/sampa_trg_cfg_seq.sv
// Trigger-enable configuration sequencer: writes C_NUM_REGS registers over AXI4-Lite,
// reads each one back, and reports response errors, readback mismatches and stalls.
module sampa_trg_cfg_seq #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_TIMEOUT = 256
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic INIT_AXI_TXN,
  input  logic [32*C_NUM_REGS-1:0] CFG_DATA,
  output logic TXN_DONE,
  output logic ERROR,
  output logic BUSY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0] M_AXI_AWPROT,
  output logic M_AXI_AWVALID,
  input  logic M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic M_AXI_WVALID,
  input  logic M_AXI_WREADY,
  input  logic [1:0] M_AXI_BRESP,
  input  logic M_AXI_BVALID,
  output logic M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0] M_AXI_ARPROT,
  output logic M_AXI_ARVALID,
  input  logic M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0] M_AXI_RRESP,
  input  logic M_AXI_RVALID,
  output logic M_AXI_RREADY
);

  // state   | meaning
  // IDLE    | never started since reset
  // WR_REQ  | AW/W channels valid for register idx
  // WR_RESP | BREADY high, waiting for write response
  // RD_REQ  | ARVALID high for register idx
  // RD_RESP | RREADY high, waiting for read data
  // DONE    | sequence finished or aborted, TXN_DONE held
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam int CW = $clog2(C_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST = IW'(C_NUM_REGS - 1);
  localparam logic [CW-1:0] TMO_LOAD = CW'(C_TIMEOUT - 1);

  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [IW-1:0] n);
    return C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({n, 2'b00});
  endfunction

  state_t state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [CW-1:0] tmo;
  logic init_q;
  logic aw_done;
  logic w_done;
  logic [C_M_AXI_DATA_WIDTH-1:0] snap [C_NUM_REGS];

  logic start;
  logic launch;
  logic waiting;
  logic progress;
  logic expire;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;

  assign idx_nxt = idx + 1'b1;
  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY & M_AXI_BVALID;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY & M_AXI_RVALID;

  assign start   = INIT_AXI_TXN & ~init_q;
  assign launch  = start & ((state == IDLE) | (state == DONE));
  assign waiting = (state == WR_REQ) | (state == WR_RESP) | (state == RD_REQ) | (state == RD_RESP);

  always_comb begin
    progress = 1'b0;
    case (state)
      WR_REQ:  progress = aw_hs | w_hs;
      WR_RESP: progress = b_hs;
      RD_REQ:  progress = ar_hs;
      RD_RESP: progress = r_hs;
      default: progress = 1'b0;
    endcase
  end

  // Any handshake restarts the stall window, so only a silent channel expires.
  assign expire = waiting & (tmo == '0) & ~progress;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_ff @(posedge ACLK) begin
    if (launch && !ARESET) begin
      for (int j = 0; j < C_NUM_REGS; j++) snap[j] <= CFG_DATA[32*j +: 32];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      idx           <= '0;
      tmo           <= '0;
      init_q        <= 1'b1;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      TXN_DONE      <= 1'b0;
      ERROR         <= 1'b0;
      BUSY          <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (waiting) tmo <= tmo - 1'b1;

      if (expire) begin
        state         <= DONE;
        idx           <= '0;
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
        ERROR         <= 1'b1;
        TXN_DONE      <= 1'b1;
        BUSY          <= 1'b0;
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_WSTRB   <= '0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state         <= WR_REQ;
              idx           <= '0;
              tmo           <= TMO_LOAD;
              TXN_DONE      <= 1'b0;
              ERROR         <= 1'b0;
              BUSY          <= 1'b1;
              M_AXI_AWADDR  <= reg_addr('0);
              M_AXI_WDATA   <= CFG_DATA[31:0];
              M_AXI_WSTRB   <= '1;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
            end
          end

          WR_REQ: begin
            if (aw_hs) M_AXI_AWVALID <= 1'b0;
            if (w_hs) begin
              M_AXI_WVALID <= 1'b0;
              M_AXI_WSTRB  <= '0;
            end
            if ((aw_done | aw_hs) && (w_done | w_hs)) begin
              aw_done      <= 1'b0;
              w_done       <= 1'b0;
              M_AXI_BREADY <= 1'b1;
              tmo          <= TMO_LOAD;
              state        <= WR_RESP;
            end else if (aw_hs | w_hs) begin
              aw_done <= aw_done | aw_hs;
              w_done  <= w_done | w_hs;
              tmo     <= TMO_LOAD;
            end
          end

          WR_RESP: begin
            if (b_hs) begin
              if (M_AXI_BRESP != 2'b00) ERROR <= 1'b1;
              M_AXI_BREADY <= 1'b0;
              tmo          <= TMO_LOAD;
              if (idx == LAST) begin
                idx           <= '0;
                M_AXI_ARADDR  <= reg_addr('0);
                M_AXI_ARVALID <= 1'b1;
                state         <= RD_REQ;
              end else begin
                idx           <= idx_nxt;
                M_AXI_AWADDR  <= reg_addr(idx_nxt);
                M_AXI_WDATA   <= snap[idx_nxt];
                M_AXI_WSTRB   <= '1;
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
                state         <= WR_REQ;
              end
            end
          end

          RD_REQ: begin
            if (ar_hs) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
              tmo           <= TMO_LOAD;
              state         <= RD_RESP;
            end
          end

          RD_RESP: begin
            if (r_hs) begin
              if ((M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != snap[idx])) ERROR <= 1'b1;
              M_AXI_RREADY <= 1'b0;
              tmo          <= TMO_LOAD;
              if (idx == LAST) begin
                idx      <= '0;
                TXN_DONE <= 1'b1;
                BUSY     <= 1'b0;
                state    <= DONE;
              end else begin
                idx           <= idx_nxt;
                M_AXI_ARADDR  <= reg_addr(idx_nxt);
                M_AXI_ARVALID <= 1'b1;
                state         <= RD_REQ;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
